ieee488_handshake: RTL and testbench
====================================

IEEE488_HANDSHAKE -- requirements
Module: ieee488_handshake

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 1024, meaning the number of ce ticks a talker wait state may last before abort.
REQ-002 SHALL have port clk  in  1  system clock.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port ce  in  1  1 MHz bus tick enable; all bus sampling and FSM transitions occur only on clk edges with ce=1.
REQ-005 SHALL have port talk_en / listen_en  in  1 each  role selects; talk_en has priority when both are high.
REQ-006 SHALL have port tx_data  in  8, tx_eoi  in  1, tx_valid  in  1, tx_ready  out  1  host byte source with valid/ready handshake.
REQ-007 SHALL have port rx_data  out  8, rx_eoi  out  1, rx_atn  out  1, rx_valid  out  1, rx_ready  in  1  host byte sink with valid/ready handshake.
REQ-008 SHALL have ports ieee488_data_i/_o (8), ieee488_dav_i/_o, ieee488_nrfd_i/_o, ieee488_ndac_i/_o, ieee488_eoi_i/_o (1 each), and ieee488_atn_i (1); all are active-low, and an output of 1 means released.
REQ-009 SHALL have port timeout  out  1, a one-clk pulse on talker abort, and port dnp  out  1, a one-clk pulse on device-not-present.

Function
REQ-010 Host-side data SHALL be true polarity; bus data SHALL be inverted (rx_data = ~ieee488_data_i, ieee488_data_o = ~tx byte).
REQ-011 FSM states SHALL be IDLE, L_READY, L_ACCEPT, L_DONE, T_WAIT_RDY, T_DAV, T_WAIT_ACC, T_RELEASE.
REQ-012 IDLE: all outputs SHALL be released; on a ce tick, ATN low or (listen_en and not talk_en) -> L_READY; otherwise talk_en with tx_valid -> T_WAIT_RDY.
REQ-013 L_READY: NDAC SHALL be driven low; NRFD SHALL be released only while receive storage has space, else held low.
REQ-014 L_READY with DAV sampled low and NRFD released: latch data, EOI (eoi_i low) and ATN (atn_i low) into storage; go to L_ACCEPT.
REQ-015 L_ACCEPT: NRFD SHALL be driven low and NDAC released; when DAV is sampled high -> L_DONE.
REQ-016 L_DONE: NDAC SHALL be driven low, then -> L_READY, or -> IDLE if neither listen_en nor ATN low.
REQ-017 tx_ready SHALL pulse for one clk when a byte is consumed in T_WAIT_RDY (captured into the output register); the host holds tx_data until then.
REQ-018 T_WAIT_RDY: drive data and EOI (if tx_eoi); if NRFD and NDAC are both sampled high -> pulse dnp, release all, -> IDLE (byte discarded); if NRFD is high and NDAC low -> T_DAV.
REQ-019 T_DAV: DAV SHALL be driven low (held at least 1 ce tick after data valid) -> T_WAIT_ACC.
REQ-020 T_WAIT_ACC: wait for NDAC sampled high -> T_RELEASE.
REQ-021 T_RELEASE: release DAV, data and EOI -> IDLE.
REQ-022 The timeout counter SHALL clear on entry to T_WAIT_RDY/T_WAIT_ACC and count ce ticks; on reaching TIMEOUT_TICKS, pulse timeout, release all lines, discard the byte, -> IDLE.
REQ-023 ATN low sampled in any T_* state SHALL abort the talk within one ce tick: release DAV, EOI and data, then -> L_READY; the in-flight byte is discarded without a tx_ready pulse unless already consumed.
REQ-024 rx_valid SHALL remain high until rx_ready is sampled high at a clk edge; a push and pop in the same clk SHALL both take effect.
REQ-025 ATN bytes SHALL be received even if listen_en=0.

Reset
REQ-026 On reset: state=IDLE; all *_o=1 (data 0xFF); rx_valid=0, tx_ready=0, timeout=0, dnp=0; storage empty; counter=0.
REQ-027 Reset asserted mid-transfer SHALL release all bus lines on the next clk edge regardless of ce.

Configuration
REQ-028 With IEEE488_RXFIFO_EN defined, receive storage SHALL be a 4-entry FIFO of {atn,eoi,data}, and NRFD SHALL be released while fewer than 4 entries are held.
REQ-029 Without IEEE488_RXFIFO_EN, storage SHALL be a single holding register, and NRFD SHALL be released only while rx_valid=0.

Verification
REQ-030 Listen with rx_ready=1: drive data_i=0xBE, DAV low -> rx_data=0x41, rx_valid, NDAC high, NRFD low; DAV high -> NDAC low.
REQ-031 Talk 0x55 with tx_eoi=1 against a modeled listener -> data_o=0xAA, eoi_o=0, DAV low, then all released after NDAC high; tx_ready pulsed once.
REQ-032 Talk with NRFD=NDAC=1 (no listener) -> dnp pulse within 2 ce ticks, lines released, state IDLE.
REQ-033 Talk where the listener never raises NDAC -> timeout pulse after exactly 1024 ce ticks, DAV released.
REQ-034 Assert ATN during T_WAIT_ACC -> DAV/data released next ce tick; the following byte is received with rx_atn=1.
REQ-035 rx_ready=0 and 5 bytes sent -> NRFD low after 1 byte (no FIFO) / 4 bytes (IEEE488_RXFIFO_EN); no byte lost after draining.

Source files
------------

// File: rtl/ieee488_handshake.sv
// ieee488_handshake: IEEE-488 DAV/NRFD/NDAC talker/listener bridging host valid/ready byte streams.
// Define IEEE488_RXFIFO_EN to use a 4-entry receive FIFO instead of a single holding register.
module ieee488_handshake #(
   parameter int TIMEOUT_TICKS = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic       talk_en,
   input  logic       listen_en,
   input  logic [7:0] tx_data,
   input  logic       tx_eoi,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_eoi,
   output logic       rx_atn,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] ieee488_data_i,
   output logic [7:0] ieee488_data_o,
   input  logic       ieee488_dav_i,
   output logic       ieee488_dav_o,
   input  logic       ieee488_nrfd_i,
   output logic       ieee488_nrfd_o,
   input  logic       ieee488_ndac_i,
   output logic       ieee488_ndac_o,
   input  logic       ieee488_eoi_i,
   output logic       ieee488_eoi_o,
   input  logic       ieee488_atn_i,
   output logic       timeout,
   output logic       dnp
);
   typedef enum logic [2:0] {IDLE, L_READY, L_ACCEPT, L_DONE, T_WAIT_RDY, T_DAV, T_WAIT_ACC, T_RELEASE} state_t;
   localparam int CW = $clog2(TIMEOUT_TICKS + 1);
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [7:0] tx_byte;
   logic tx_eoi_q, atn_low, expired, talking, load, push, pop, space, dnp_nx, timeout_nx;
   logic [9:0] rx_word, wr_word;
   assign atn_low = ~ieee488_atn_i;
   assign expired = cnt == CW'(TIMEOUT_TICKS - 1);
   assign load = state == IDLE && state_nx == T_WAIT_RDY;
   assign pop = rx_valid & rx_ready;
   assign wr_word = {atn_low, ~ieee488_eoi_i, ~ieee488_data_i};
   assign {rx_atn, rx_eoi, rx_data} = rx_word;
   always_comb begin
      state_nx = state;
      push = 1'b0;
      dnp_nx = 1'b0;
      timeout_nx = 1'b0;
      if (ce)
         case (state)
            IDLE:
               if (atn_low || (listen_en && !talk_en)) state_nx = L_READY;
               else if (talk_en && tx_valid) state_nx = T_WAIT_RDY;
            L_READY:
               if (!ieee488_dav_i && space) begin
                  push = 1'b1;
                  state_nx = L_ACCEPT;
               end else if (ieee488_dav_i && !listen_en && !atn_low) state_nx = IDLE;
            L_ACCEPT: if (ieee488_dav_i) state_nx = L_DONE;
            L_DONE: state_nx = (listen_en || atn_low) ? L_READY : IDLE;
            T_WAIT_RDY:
               if (atn_low) state_nx = L_READY;
               else if (ieee488_nrfd_i && ieee488_ndac_i) begin
                  dnp_nx = 1'b1;
                  state_nx = IDLE;
               end else if (ieee488_nrfd_i) state_nx = T_DAV;
               else if (expired) begin
                  timeout_nx = 1'b1;
                  state_nx = IDLE;
               end
            T_DAV: state_nx = atn_low ? L_READY : T_WAIT_ACC;
            T_WAIT_ACC:
               if (atn_low) state_nx = L_READY;
               else if (ieee488_ndac_i) state_nx = T_RELEASE;
               else if (expired) begin
                  timeout_nx = 1'b1;
                  state_nx = IDLE;
               end
            T_RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
   end
   // Bus lines follow the state directly so a reset releases them on the very next clk.
   assign talking = state inside {T_WAIT_RDY, T_DAV, T_WAIT_ACC};
   assign ieee488_data_o = talking ? ~tx_byte : 8'hFF;
   assign ieee488_eoi_o = !(talking && tx_eoi_q);
   assign ieee488_dav_o = !(state inside {T_DAV, T_WAIT_ACC});
   assign ieee488_nrfd_o = state == L_READY ? space : !(state inside {L_ACCEPT, L_DONE});
   assign ieee488_ndac_o = !(state inside {L_READY, L_DONE});
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         tx_byte <= '0;
         tx_eoi_q <= 1'b0;
         tx_ready <= 1'b0;
         dnp <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state <= state_nx;
         dnp <= dnp_nx;
         timeout <= timeout_nx;
         tx_ready <= load;
         if (load) begin
            tx_byte <= tx_data;
            tx_eoi_q <= tx_eoi;
         end
         if (state_nx != state && state_nx inside {T_WAIT_RDY, T_WAIT_ACC}) cnt <= '0;
         else if (ce) cnt <= cnt + 1'b1;
      end
   end
`ifdef IEEE488_RXFIFO_EN
   logic [9:0] mem [4];
   logic [1:0] wp, rp;
   logic [2:0] fill;
   assign space = fill != 3'd4;
   assign rx_valid = fill != 3'd0;
   assign rx_word = mem[rp];
   always_ff @(posedge clk) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
         fill <= '0;
      end else begin
         if (push) mem[wp] <= wr_word;
         wp <= wp + 2'(push);
         rp <= rp + 2'(pop);
         fill <= fill + 3'(push) - 3'(pop);
      end
   end
`else
   logic [9:0] hold;
   logic full;
   assign space = !full;
   assign rx_valid = full;
   assign rx_word = hold;
   always_ff @(posedge clk) begin
      if (reset) begin
         hold <= '0;
         full <= 1'b0;
      end else begin
         full <= push | (full & ~pop);
         if (push) hold <= wr_word;
      end
   end
`endif
endmodule

// File: tb/tb_ieee488_handshake.sv
// tb_ieee488_handshake: randomized talker/listener bus partner with byte scoreboard for ieee488_handshake.
module tb_ieee488_handshake;
   localparam int TICKS = 1024;
`ifdef IEEE488_RXFIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif
   logic clk = 0, reset = 1, talk_en = 0, listen_en = 0, tx_eoi = 0, tx_valid = 0, rx_ready = 0;
   logic [7:0] tx_data = 0;
   logic [1:0] ce_cnt = 0;
   logic ce, tx_ready, rx_eoi, rx_atn, rx_valid, timeout, dnp;
   logic [7:0] rx_data, data_o, data_i;
   logic dav_o, nrfd_o, ndac_o, eoi_o, dav_i, nrfd_i, ndac_i, eoi_i, atn_i;
   logic [7:0] tb_data = 8'hFF;
   logic tb_dav = 1, tb_nrfd = 1, tb_ndac = 1, tb_eoi = 1, tb_atn = 1;
   int n_tests = 0, n_fail = 0, n_txr = 0, n_dnp = 0, n_to = 0;
   bit rand_rdy = 0;
   logic [9:0] exp_q[$], got_q[$];
   // Open-collector bus: each line is the wired-AND of the DUT and the bench partner.
   assign data_i = data_o & tb_data;
   assign dav_i = dav_o & tb_dav;
   assign nrfd_i = nrfd_o & tb_nrfd;
   assign ndac_i = ndac_o & tb_ndac;
   assign eoi_i = eoi_o & tb_eoi;
   assign atn_i = tb_atn;
   assign ce = ce_cnt == 2'd3;
   always #5 clk = ~clk;
   always @(posedge clk) ce_cnt <= ce_cnt + 2'd1;
   ieee488_handshake dut (
      .clk(clk), .reset(reset), .ce(ce), .talk_en(talk_en), .listen_en(listen_en),
      .tx_data(tx_data), .tx_eoi(tx_eoi), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_eoi(rx_eoi), .rx_atn(rx_atn), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .ieee488_data_i(data_i), .ieee488_data_o(data_o), .ieee488_dav_i(dav_i), .ieee488_dav_o(dav_o),
      .ieee488_nrfd_i(nrfd_i), .ieee488_nrfd_o(nrfd_o), .ieee488_ndac_i(ndac_i), .ieee488_ndac_o(ndac_o),
      .ieee488_eoi_i(eoi_i), .ieee488_eoi_o(eoi_o), .ieee488_atn_i(atn_i),
      .timeout(timeout), .dnp(dnp)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // One clk: record the pop the coming edge will make, then sample pulses at the negedge.
   task automatic step();
      if (rx_valid && rx_ready) got_q.push_back({rx_atn, rx_eoi, rx_data});
      @(negedge clk);
      if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
      if (tx_ready) begin
         n_txr++;
         tx_valid = 0;
      end
      n_dnp += int'(dnp);
      n_to += int'(timeout);
   endtask
   task automatic ce_step();
      while (!ce) step();
      step();
   endtask
   task automatic send(input logic [7:0] d, input logic e, input logic a, output bit ok);
      tb_atn = ~a;
      for (int k = 0; k < 60 && !(nrfd_i && !ndac_i); k++) step();
      ok = nrfd_i && !ndac_i;
      if (!ok) tb_atn = 1;
      else begin
         tb_data = ~d;
         tb_eoi = ~e;
         ce_step();
         tb_dav = 0;
         for (int k = 0; k < 60 && !ndac_i; k++) step();
         check("send_ack", ndac_i, 1);
         tb_dav = 1;
         tb_data = 8'hFF;
         tb_eoi = 1;
         tb_atn = 1;
         ce_step();
         ce_step();
      end
   endtask
   task automatic recv(output logic [7:0] d, output logic e);
      tb_ndac = 0;
      tb_nrfd = 0;
      repeat ($urandom_range(0, 8)) step();
      tb_nrfd = 1;
      for (int k = 0; k < 80 && dav_i; k++) step();
      check("recv_dav", dav_i, 0);
      d = ~data_i;
      e = ~eoi_i;
      tb_nrfd = 0;
      repeat ($urandom_range(0, 8)) step();
      tb_ndac = 1;
      for (int k = 0; k < 80 && !dav_i; k++) step();
      check("recv_release", {data_o, eoi_o, dav_o}, 10'h3FF);
   endtask
   task automatic compare_rx(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [7:0] d, bp [5];
      logic e, a;
      bit ok;
      int n0, ticks, acc;
      repeat (4) step();
      check("reset_lines", {data_o, dav_o, nrfd_o, ndac_o, eoi_o}, 12'hFFF);
      check("reset_flags", {rx_valid, tx_ready, timeout, dnp}, 4'h0);
      reset = 0;
      // directed listen of bus byte 0xBE
      rx_ready = 1;
      listen_en = 1;
      ce_step();
      ce_step();
      check("l_ready_lines", {nrfd_o, ndac_o}, 2'b10);
      tb_data = 8'hBE;
      tb_dav = 0;
      ce_step();
      check("rx_data", rx_data, 8'h41);
      check("rx_valid", rx_valid, 1);
      check("accept_lines", {nrfd_o, ndac_o}, 2'b01);
      tb_dav = 1;
      tb_data = 8'hFF;
      ce_step();
      check("done_ndac", ndac_o, 0);
      ce_step();
      got_q.delete();
      // random listen with random host backpressure
      rand_rdy = 1;
      for (int i = 0; i < 12; i++) begin
         d = 8'($urandom);
         e = 1'($urandom_range(0, 1));
         a = $urandom_range(0, 3) == 0;
         send(d, e, a, ok);
         check("send_ok", ok, 1);
         if (ok) exp_q.push_back({a, e, d});
      end
      rand_rdy = 0;
      rx_ready = 1;
      repeat (8) step();
      compare_rx("rx_rand");
      // storage fills with host stalled, then drains without loss
      rx_ready = 0;
      foreach (bp[i]) bp[i] = 8'($urandom);
      acc = 0;
      ok = 1;
      for (int i = 0; i < 5 && ok; i++) begin
         send(bp[i], 0, 0, ok);
         if (ok) begin
            exp_q.push_back({2'b00, bp[i]});
            acc++;
         end
      end
      check("bp_accepted", acc, DEPTH);
      check("bp_nrfd", nrfd_i, 0);
      rx_ready = 1;
      for (int i = acc; i < 5; i++) begin
         send(bp[i], 0, 0, ok);
         exp_q.push_back({2'b00, bp[i]});
      end
      repeat (8) step();
      compare_rx("rx_bp");
      listen_en = 0;
      ce_step();
      ce_step();
      check("listen_off", ndac_o, 1);
      // directed talk 0x55 with EOI
      talk_en = 1;
      tb_nrfd = 1;
      tb_ndac = 0;
      tx_data = 8'h55;
      tx_eoi = 1;
      tx_valid = 1;
      n_txr = 0;
      for (int k = 0; k < 40 && dav_i; k++) step();
      check("t_dav", dav_o, 0);
      check("t_data", data_o, 8'hAA);
      check("t_eoi", eoi_o, 0);
      tb_nrfd = 0;
      tb_ndac = 1;
      for (int k = 0; k < 40 && !dav_o; k++) step();
      check("t_release", {data_o, eoi_o, dav_o}, 10'h3FF);
      check("t_txready", n_txr, 1);
      ce_step();
      // random talk against a listener with random delays
      for (int i = 0; i < 8; i++) begin
         logic [8:0] want;
         want = {1'($urandom_range(0, 1)), 8'($urandom)};
         {tx_eoi, tx_data} = want;
         tx_valid = 1;
         n0 = n_txr;
         recv(d, e);
         check("tx_byte", {e, d}, want);
         check("tx_ready_once", n_txr - n0, 1);
         ce_step();
      end
      // no listener present
      tb_nrfd = 1;
      tb_ndac = 1;
      n0 = n_dnp;
      tx_valid = 1;
      ce_step();
      ce_step();
      check("dnp_pulse", n_dnp - n0, 1);
      check("dnp_release", {data_o, eoi_o, dav_o}, 10'h3FF);
      ce_step();
      ce_step();
      check("dnp_idle", {data_o, dav_o, n_dnp - n0 == 1}, 10'h3FF);
      // listener never acknowledges
      tb_nrfd = 1;
      tb_ndac = 0;
      tx_valid = 1;
      for (int k = 0; k < 40 && dav_i; k++) step();
      check("to_dav", dav_o, 0);
      tb_nrfd = 0;
      ce_step();
      n0 = n_to;
      ticks = 0;
      while (n_to == n0 && ticks < TICKS + 20) begin
         ce_step();
         ticks++;
      end
      check("timeout_ticks", ticks, TICKS);
      check("timeout_release", {data_o, eoi_o, dav_o}, 10'h3FF);
      // ATN aborts a talk in T_WAIT_ACC, then an ATN byte is received
      tb_nrfd = 1;
      tx_valid = 1;
      for (int k = 0; k < 40 && dav_i; k++) step();
      tb_nrfd = 0;
      ce_step();
      check("atn_pre", dav_o, 0);
      talk_en = 0;
      tb_atn = 0;
      ce_step();
      check("atn_abort", {data_o, eoi_o, dav_o}, 10'h3FF);
      check("atn_listen", ndac_o, 0);
      tb_nrfd = 1;
      tb_ndac = 1;
      rx_ready = 1;
      got_q.delete();
      send(8'h3C, 0, 1, ok);
      exp_q.push_back({2'b10, 8'h3C});
      repeat (4) step();
      compare_rx("rx_atn");
      // reset mid-transfer releases the bus on a non-ce edge
      talk_en = 1;
      tb_nrfd = 1;
      tb_ndac = 0;
      tx_valid = 1;
      for (int k = 0; k < 40 && dav_i; k++) step();
      check("mid_dav", dav_o, 0);
      while (ce) step();
      reset = 1;
      step();
      check("reset_mid", {data_o, eoi_o, dav_o, nrfd_o, ndac_o}, 12'hFFF);
      reset = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
